// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, line
// levels of the framing bits, frame length and the parity helper.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit between
// the last data bit and the stop bit (11-bit frames instead of 10).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick is high on the last clk cycle of every
// CLKS_PER_BIT-cycle bit period. restart forces the next cycle to be the
// first cycle of a fresh bit period, aligning the timer to a new frame.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..CLKS_PER_BIT-1 and wrap; restart realigns to zero.
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO_DEPTH-byte input FIFO feeding a start/8N/stop
// serialiser with a registered, idle-high tx line.
// Build option: UART_TX_PARITY_EN (see uart_pkg) enables an even-parity
// bit through the PARITY state; without it PARITY is never entered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam bit               PARITY_EN = (FRAME_BITS == 11);

    // FIFO
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    // Serialiser
    uart_state_t      state;
    uart_state_t      state_next;
    logic [7:0]       data_q;
    logic [2:0]       bit_idx;
    logic             tick;
    logic             restart;
    logic             tx_next;

    assign push       = tx_valid && tx_ready;
    assign fifo_empty = (fifo_cnt == '0);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    // Occupancy after this edge; push and pop together leave it unchanged.
    // NOTE: every path assigns a default first, so no latch is inferred.
    always_comb begin
        cnt_next = fifo_cnt;
        case ({push, pop})
            2'b10:   cnt_next = fifo_cnt + CNT_W'(1);
            2'b01:   cnt_next = fifo_cnt - CNT_W'(1);
            default: cnt_next = fifo_cnt;
        endcase
    end

    // Byte storage; only slots between rd_ptr and wr_ptr are ever read.
    // NOTE: the array is not reset -- fifo_cnt alone says what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= cnt_next;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; a pop loads the shifter and restarts the bit timer.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        restart    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    restart    = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (tick) state_next = DATA;
            end
            DATA: begin
                if (tick && bit_idx == 3'd7) begin
                    state_next = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick) state_next = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        restart    = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shifter: capture the head byte on pop, step the bit index per data bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            bit_idx <= '0;
        end else if (pop) begin
            data_q  <= fifo_mem[rd_ptr];
            bit_idx <= '0;
        end else if (state == DATA && tick) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // Line level implied by the current state.
    always_comb begin
        tx_next = STOP_BIT;
        case (state)
            START:   tx_next = START_BIT;
            DATA:    tx_next = data_q[bit_idx];
            PARITY:  tx_next = even_parity(data_q);
            default: tx_next = STOP_BIT;
        endcase
    end

    // Registered outputs; tx trails the FSM by one cycle, and busy is timed
    // so it drops together with the end of the last stop bit on tx.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_ready <= 1'b0;
        end else begin
            tx       <= tx_next;
            busy     <= (state != IDLE) || !fifo_empty || push;
            tx_ready <= (cnt_next != FULL_CNT);
        end
    end

endmodule
